// File: rtl/vga_sync_decoder_if.sv
// Sync inputs from a VGA timing source and the recovered timing produced
// by the decoder.
interface vga_sync_decoder_if;
  logic        hsync;
  logic        vsync;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        locked;
  logic        de;
  logic        new_frame;
  logic        sync_err;
  logic [7:0]  err_cnt;

  // Timing source side: drives the syncs, observes the decoder results.
  modport master (
    output hsync,
    output vsync,
    input  hcount,
    input  vcount,
    input  locked,
    input  de,
    input  new_frame,
    input  sync_err,
    input  err_cnt
  );

  // Decoder side.
  modport slave (
    input  hsync,
    input  vsync,
    output hcount,
    output vcount,
    output locked,
    output de,
    output new_frame,
    output sync_err,
    output err_cnt
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line position from incoming hsync/vsync, checks the sync
// edges against the expected timing and reports lock, data enable, frame
// start and timing errors.
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL   = 1344,
  parameter int unsigned H_S_START = 1048,
  parameter int unsigned H_S_END   = 1184,
  parameter int unsigned H_ACTIVE  = 1024,
  parameter int unsigned V_TOTAL   = 806,
  parameter int unsigned V_S_START = 771,
  parameter int unsigned V_S_END   = 777,
  parameter int unsigned V_ACTIVE  = 768
) (
  input  logic              clk,
  input  logic              rst,
  vga_sync_decoder_if.slave bus
);

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_SS   = 11'(H_S_START);
  localparam logic [10:0] H_SS1  = 11'(H_S_START + 1);
  localparam logic [10:0] H_SE   = 11'(H_S_END);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_SS   = 11'(V_S_START);
  localparam logic [10:0] V_SE   = 11'(V_S_END);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);

  // Missing-hsync watchdog: cycles since the last detected hsync rise.
  localparam int unsigned    TO_MAX  = 2 * H_TOTAL;
  localparam int unsigned    TO_W    = $clog2(TO_MAX + 1);
  localparam logic [TO_W-1:0] TO_LIM  = TO_W'(TO_MAX);
  localparam logic [TO_W-1:0] TO_FIRE = TO_W'(TO_MAX - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  typedef enum logic [1:0] {
    SEARCH,
    H_ALIGNED,
    V_ALIGNED,
    LOCKED
  } state_e;

  state_e state_q, state_d;

  logic            hs_q, hs_qq, vs_q, vs_qq;
  logic            h_rise, h_fall, v_rise, v_fall;
  logic [10:0]     h_q, h_d, v_q, v_d;
  logic [10:0]     hcount_q, vcount_q;
  logic [TO_W-1:0] to_q, to_d;
  logic            timeout;
  logic            h_mismatch, v_mismatch;
  logic            err_d, sync_err_q;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            locked, de, new_frame;

  // Edge detection on the registered syncs and edge-position checks.
  // The internal counters run one clock behind the source, so they hold the
  // source position of the sync sample currently in hs_q/vs_q.
  always_comb begin
    h_rise     = hs_q & ~hs_qq;
    h_fall     = ~hs_q & hs_qq;
    v_rise     = vs_q & ~vs_qq;
    v_fall     = ~vs_q & vs_qq;
    h_mismatch = (h_rise && (h_q != H_SS)) || (h_fall && (h_q != H_SE));
    v_mismatch = (v_rise && ((v_q != V_SS) || (h_q != H_SS))) ||
                 (v_fall && ((v_q != V_SE) || (h_q != H_SS)));
  end

  // Free-running position counters with realignment on sync rises; an
  // hsync rise replaces the normal increment, so it never causes a line wrap,
  // and a coincident vsync rise still overrides the line number.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (h_rise) begin
      h_d = H_SS1;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
    end else begin
      h_d = h_q + 11'd1;
    end
    if (v_rise) begin
      v_d = V_SS;
    end
  end

  // Watchdog fires once when no hsync rise has been seen for 2*H_TOTAL clocks.
  always_comb begin
    timeout = !h_rise && (to_q == TO_FIRE);
    if (h_rise) begin
      to_d = '0;
    end else if (to_q == TO_LIM) begin
      to_d = to_q;
    end else begin
      to_d = to_q + TO_ONE;
    end
  end

  // Lock state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Lock acquisition and loss.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH: begin
        if (h_rise) state_d = H_ALIGNED;
      end
      H_ALIGNED: begin
        if (timeout)     state_d = SEARCH;
        else if (v_rise) state_d = V_ALIGNED;
      end
      V_ALIGNED: begin
        if (h_mismatch || timeout) state_d = SEARCH;
        else if (v_rise)           state_d = LOCKED;
      end
      LOCKED: begin
        if (h_mismatch || v_mismatch || timeout) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
  end

  // Status outputs derived from the state and the output counters.
  always_comb begin
    locked    = (state_q == LOCKED);
    de        = locked && (hcount_q < H_ACT) && (vcount_q < V_ACT);
    new_frame = locked && (hcount_q == '0) && (vcount_q == '0);
    err_d     = locked && (h_mismatch || v_mismatch || timeout);
    err_cnt_d = (err_d && (err_cnt_q != '1)) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  // Sync capture, counters, watchdog and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q       <= 1'b0;
      hs_qq      <= 1'b0;
      vs_q       <= 1'b0;
      vs_qq      <= 1'b0;
      h_q        <= '0;
      v_q        <= '0;
      hcount_q   <= '0;
      vcount_q   <= '0;
      to_q       <= '0;
      sync_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      hs_q       <= bus.hsync;
      hs_qq      <= hs_q;
      vs_q       <= bus.vsync;
      vs_qq      <= vs_q;
      h_q        <= h_d;
      v_q        <= v_d;
      hcount_q   <= h_q;
      vcount_q   <= v_q;
      to_q       <= to_d;
      sync_err_q <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.hcount    = hcount_q;
  assign bus.vcount    = vcount_q;
  assign bus.locked    = locked;
  assign bus.de        = de;
  assign bus.new_frame = new_frame;
  assign bus.sync_err  = sync_err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule
